// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The LSU uses the slave modport; the pipeline/memory side uses master.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, busy, done, ld_valid, ld_data, err,
    output mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, busy, done, ld_valid, ld_data, err,
    input  mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word accesses to a big-endian word memory,
// with read-modify-write for sub-word stores and a configurable per-phase wait.
module load_store_unit #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned CNT_W       = 4
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             write_q;
  logic             signed_q;
  logic [1:0]       size_q;
  logic [1:0]       lane_q;
  logic [29:0]      word_addr_q;
  logic [31:0]      wdata_q;

  logic             busy_q;
  logic             done_q;
  logic             ld_valid_q;
  logic             err_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic [31:0]      ld_data_q;
  logic [31:0]      mem_address_q;
  logic [31:0]      mem_write_data_q;

  logic             misaligned;
  logic             cnt_last;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      ld_extract;
  logic [31:0]      st_merge;

  assign cnt_last = (cnt_q == CNT_W'(WAIT_CYCLES));

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Byte 0 of the word (lowest address) sits in the most significant lane.
  always_comb begin
    rd_byte = bus.mem_read_data[7:0];
    case (lane_q)
      2'd0:    rd_byte = bus.mem_read_data[31:24];
      2'd1:    rd_byte = bus.mem_read_data[23:16];
      2'd2:    rd_byte = bus.mem_read_data[15:8];
      default: rd_byte = bus.mem_read_data[7:0];
    endcase
    rd_half = lane_q[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];

    ld_extract = bus.mem_read_data;
    case (size_q)
      2'd0:    ld_extract = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'd1:    ld_extract = {{16{signed_q & rd_half[15]}}, rd_half};
      default: ld_extract = bus.mem_read_data;
    endcase

    st_merge = bus.mem_read_data;
    case (size_q)
      2'd0: begin
        case (lane_q)
          2'd0:    st_merge[31:24] = wdata_q[7:0];
          2'd1:    st_merge[23:16] = wdata_q[7:0];
          2'd2:    st_merge[15:8]  = wdata_q[7:0];
          default: st_merge[7:0]   = wdata_q[7:0];
        endcase
      end
      2'd1: begin
        if (lane_q[1]) st_merge[15:0]  = wdata_q[15:0];
        else           st_merge[31:16] = wdata_q[15:0];
      end
      default: st_merge = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      write_q          <= 1'b0;
      signed_q         <= 1'b0;
      size_q           <= 2'd0;
      lane_q           <= 2'd0;
      word_addr_q      <= '0;
      wdata_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      ld_valid_q       <= 1'b0;
      err_q            <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      ld_data_q        <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
    end else begin
      // Completion flags are single-cycle pulses.
      done_q     <= 1'b0;
      ld_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ld_data_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            signed_q    <= bus.req_signed;
            size_q      <= bus.req_size;
            lane_q      <= bus.req_addr[1:0];
            word_addr_q <= bus.req_addr[31:2];
            wdata_q     <= bus.req_wdata;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            if (misaligned) begin
              state_q <= StFin;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (!bus.req_write || bus.req_size != 2'd2) begin
              state_q       <= StRd;
              mem_read_q    <= 1'b1;
              mem_address_q <= {bus.req_addr[31:2], 2'b00};
            end else begin
              state_q          <= StWr;
              mem_write_q      <= 1'b1;
              mem_address_q    <= {bus.req_addr[31:2], 2'b00};
              mem_write_data_q <= bus.req_wdata;
            end
          end
        end
        StRd: begin
          if (cnt_last) begin
            mem_read_q <= 1'b0;
            cnt_q      <= '0;
            if (write_q) begin
              state_q          <= StWr;
              mem_write_q      <= 1'b1;
              mem_write_data_q <= st_merge;
            end else begin
              state_q       <= StFin;
              mem_address_q <= '0;
              done_q        <= 1'b1;
              ld_valid_q    <= 1'b1;
              ld_data_q     <= ld_extract;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWr: begin
          if (cnt_last) begin
            state_q          <= StFin;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            done_q           <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready      = ~busy_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.ld_valid       = ld_valid_q;
  assign bus.ld_data        = ld_data_q;
  assign bus.err            = err_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (WAIT_CYCLES 0 and 2) share one memory
// model; expected completions go through a scoreboard queue.
module tb_load_store_unit;

  typedef struct packed {
    logic        err;
    logic        ldv;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus0 ();
  load_store_unit_if bus2 ();

  load_store_unit #(.WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  load_store_unit #(.WAIT_CYCLES(2), .CNT_W(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic        sel = 1'b0;
  logic        rq_valid = 1'b0;
  logic        rq_write = 1'b0;
  logic [1:0]  rq_size = 2'd0;
  logic        rq_signed = 1'b0;
  logic [31:0] rq_addr = '0;
  logic [31:0] rq_wdata = '0;

  assign bus0.req_valid  = rq_valid & ~sel;
  assign bus2.req_valid  = rq_valid & sel;
  assign bus0.req_write  = rq_write;
  assign bus2.req_write  = rq_write;
  assign bus0.req_size   = rq_size;
  assign bus2.req_size   = rq_size;
  assign bus0.req_signed = rq_signed;
  assign bus2.req_signed = rq_signed;
  assign bus0.req_addr   = rq_addr;
  assign bus2.req_addr   = rq_addr;
  assign bus0.req_wdata  = rq_wdata;
  assign bus2.req_wdata  = rq_wdata;

  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (bus0.mem_write) mem[bus0.mem_address[11:2]] <= bus0.mem_write_data;
    else if (bus2.mem_write) mem[bus2.mem_address[11:2]] <= bus2.mem_write_data;
  end

  assign bus0.mem_read_data = mem[bus0.mem_address[11:2]];
  assign bus2.mem_read_data = mem[bus2.mem_address[11:2]];

  logic        s_ready, s_busy, s_done, s_ldv, s_err, s_rd, s_wr;
  logic [31:0] s_ld_data, s_addr, s_wdata;
  assign s_ready   = sel ? bus2.req_ready      : bus0.req_ready;
  assign s_busy    = sel ? bus2.busy           : bus0.busy;
  assign s_done    = sel ? bus2.done           : bus0.done;
  assign s_ldv     = sel ? bus2.ld_valid       : bus0.ld_valid;
  assign s_err     = sel ? bus2.err            : bus0.err;
  assign s_rd      = sel ? bus2.mem_read       : bus0.mem_read;
  assign s_wr      = sel ? bus2.mem_write      : bus0.mem_write;
  assign s_ld_data = sel ? bus2.ld_data        : bus0.ld_data;
  assign s_addr    = sel ? bus2.mem_address    : bus0.mem_address;
  assign s_wdata   = sel ? bus2.mem_write_data : bus0.mem_write_data;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    pre_en   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Called #1 after a posedge; returns #1 after the edge that leaves FIN.
  task automatic run_req(input string tag, input logic s, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_data, input int e_lat,
                         input int e_rd, input int e_wr, input logic [31:0] e_wdat,
                         input logic hold);
    exp_t        e, got_e;
    int          n = 0, rd = 0, wr = 0, ready_bad = 0;
    logic        got = 1'b0;
    logic [31:0] raddr = '0, waddr = '0, wdat = '0;
    e.err  = e_err;
    e.ldv  = !w && !e_err;
    e.data = e.ldv ? e_data : 32'h0;
    sb_q.push_back(e);
    got_e = '0;
    sel = s; rq_write = w; rq_size = sz; rq_signed = sg; rq_addr = a; rq_wdata = wd;
    rq_valid = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    // Scramble fields: they must not be re-sampled after acceptance.
    rq_addr = ~a; rq_wdata = ~wd; rq_size = ~sz; rq_write = ~w; rq_signed = ~sg;
    if (!hold) rq_valid = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (s_rd) begin rd++; raddr = s_addr; end
      if (s_wr) begin wr++; waddr = s_addr; wdat = s_wdata; end
      if (hold && s_ready) ready_bad++;
      if (s_done) begin
        got = 1'b1;
        got_e.err = s_err; got_e.ldv = s_ldv; got_e.data = s_ld_data;
      end
    end
    rq_valid = 1'b0;
    e = sb_q.pop_front();
    check({tag, "_latency"}, n, e_lat);
    check({tag, "_err"}, {31'b0, got_e.err}, {31'b0, e.err});
    check({tag, "_ld_valid"}, {31'b0, got_e.ldv}, {31'b0, e.ldv});
    check({tag, "_ld_data"}, got_e.data, e.data);
    check({tag, "_rd_cycles"}, rd, e_rd);
    check({tag, "_wr_cycles"}, wr, e_wr);
    if (e_rd > 0) check({tag, "_rd_addr"}, raddr, {a[31:2], 2'b00});
    if (e_wr > 0) begin
      check({tag, "_wr_addr"}, waddr, {a[31:2], 2'b00});
      check({tag, "_wr_data"}, wdat, e_wdat);
    end
    if (hold) check({tag, "_busy_ready"}, ready_bad, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {30'b0, s_done, s_busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {22'b0, bus0.busy, bus0.done, bus0.ld_valid, bus0.err, bus0.mem_read, bus0.mem_write,
           bus2.busy, bus2.done, bus2.mem_read, bus2.mem_write}, 32'd0);
    check("reset_ld_data", bus0.ld_data, 32'd0);
    check("reset_mem_address", bus0.mem_address | bus2.mem_address, 32'd0);
    check("reset_mem_wdata", bus0.mem_write_data | bus2.mem_write_data, 32'd0);
    check("reset_ready", {30'b0, bus0.req_ready, bus2.req_ready}, 32'd3);
    @(posedge clk);
    #1 rst = 1'b0;
    preload(10'd0, 32'h0000_03E8);
    preload(10'd250, 32'h0000_006E);

    // WAIT_CYCLES = 0 loads
    run_req("lw0",   1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 1'b0, 32'h0000_03E8, 2, 1, 0, 32'h0, 1'b0);
    run_req("lb3s",  1'b0, 1'b0, 2'd0, 1'b1, 32'd3, 32'h0, 1'b0, 32'hFFFF_FFE8, 2, 1, 0, 32'h0, 1'b0);
    run_req("lbu3",  1'b0, 1'b0, 2'd0, 1'b0, 32'd3, 32'h0, 1'b0, 32'h0000_00E8, 2, 1, 0, 32'h0, 1'b0);
    run_req("lh2s",  1'b0, 1'b0, 2'd1, 1'b1, 32'd2, 32'h0, 1'b0, 32'h0000_03E8, 2, 1, 0, 32'h0, 1'b0);
    run_req("lh0s",  1'b0, 1'b0, 2'd1, 1'b1, 32'd0, 32'h0, 1'b0, 32'h0000_0000, 2, 1, 0, 32'h0, 1'b0);
    run_req("lb2s",  1'b0, 1'b0, 2'd0, 1'b1, 32'd2, 32'h0, 1'b0, 32'h0000_0003, 2, 1, 0, 32'h0, 1'b0);

    // WAIT_CYCLES = 0 stores
    run_req("sb1001", 1'b0, 1'b1, 2'd0, 1'b0, 32'd1001, 32'h1234_56AB, 1'b0, 32'h0, 3, 1, 1,
            32'h00AB_006E, 1'b0);
    run_req("lw1000a", 1'b0, 1'b0, 2'd2, 1'b0, 32'd1000, 32'h0, 1'b0, 32'h00AB_006E, 2, 1, 0,
            32'h0, 1'b0);
    run_req("sh1002", 1'b0, 1'b1, 2'd1, 1'b0, 32'd1002, 32'hFFFF_8001, 1'b0, 32'h0, 3, 1, 1,
            32'h00AB_8001, 1'b0);
    run_req("lh1002s", 1'b0, 1'b0, 2'd1, 1'b1, 32'd1002, 32'h0, 1'b0, 32'hFFFF_8001, 2, 1, 0,
            32'h0, 1'b0);
    run_req("lhu1002", 1'b0, 1'b0, 2'd1, 1'b0, 32'd1002, 32'h0, 1'b0, 32'h0000_8001, 2, 1, 0,
            32'h0, 1'b0);
    run_req("sw8", 1'b0, 1'b1, 2'd2, 1'b0, 32'd8, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 0, 1,
            32'hCAFE_F00D, 1'b0);
    run_req("lw8", 1'b0, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 1, 0, 32'h0, 1'b0);

    // Misaligned / illegal requests
    run_req("err_lh1", 1'b0, 1'b0, 2'd1, 1'b1, 32'd1, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0);
    run_req("err_lw6", 1'b0, 1'b0, 2'd2, 1'b0, 32'd6, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0);
    run_req("err_sz3", 1'b0, 1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0);
    run_req("err_sh3", 1'b0, 1'b1, 2'd1, 1'b0, 32'd3, 32'h5555, 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0);

    // WAIT_CYCLES = 2, with a competing request held high while busy
    run_req("w2_lw1000", 1'b1, 1'b0, 2'd2, 1'b0, 32'd1000, 32'h0, 1'b0, 32'h00AB_8001, 4, 3, 0,
            32'h0, 1'b1);
    run_req("w2_sb1003", 1'b1, 1'b1, 2'd0, 1'b0, 32'd1003, 32'h0000_0055, 1'b0, 32'h0, 7, 3, 3,
            32'h00AB_8055, 1'b0);
    run_req("w2_lhu1000", 1'b1, 1'b0, 2'd1, 1'b0, 32'd1000, 32'h0, 1'b0, 32'h0000_00AB, 4, 3, 0,
            32'h0, 1'b0);
    run_req("w2_sw8", 1'b1, 1'b1, 2'd2, 1'b0, 32'd8, 32'h1234_5678, 1'b0, 32'h0, 4, 0, 3,
            32'h1234_5678, 1'b0);
    run_req("w2_lw8", 1'b1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b0, 32'h1234_5678, 4, 3, 0, 32'h0, 1'b0);

    // Reset in the read phase of a sub-word store drops the pending write
    sel = 1'b1; rq_write = 1'b1; rq_size = 2'd0; rq_signed = 1'b0;
    rq_addr = 32'd1000; rq_wdata = 32'h0000_0011; rq_valid = 1'b1;
    @(posedge clk);
    #1 rq_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_rd_active", {31'b0, s_rd}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_flags", {25'b0, s_busy, s_done, s_ldv, s_err, s_rd, s_wr, s_ready}, 32'd1);
    check("rst_mid_data", s_ld_data | s_addr | s_wdata, 32'd0);
    run_req("post_rst_lw1000", 1'b1, 1'b0, 2'd2, 1'b0, 32'd1000, 32'h0, 1'b0, 32'h00AB_8055, 4, 3, 0,
            32'h0, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
